// File: rtl/sevenseg_pkg.sv
// Seven-segment pattern constants shared by the decoder and the scanner.
// Latency: none (constants only).
// Backpressure: none.
//
// Patterns are abc_defg with bit 6 = segment a, 1 = lit (before any
// output polarity inversion).
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/sevenseg_hexdec.sv
// Nibble to seven-segment decoder (0-9 always, A-F only in hex mode).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_nibble    4-bit digit value
//   i_hex_mode  1: 10-15 show A,b,C,d,E,F; 0: 10-15 show blank
//   o_pattern   abc_defg pattern, bit 6 = a, 1 = lit
module sevenseg_hexdec
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_pattern
);

  always_comb begin
    o_pattern = SEG_BLANK;
    case (i_nibble)
      4'h0: o_pattern = SEG_0;
      4'h1: o_pattern = SEG_1;
      4'h2: o_pattern = SEG_2;
      4'h3: o_pattern = SEG_3;
      4'h4: o_pattern = SEG_4;
      4'h5: o_pattern = SEG_5;
      4'h6: o_pattern = SEG_6;
      4'h7: o_pattern = SEG_7;
      4'h8: o_pattern = SEG_8;
      4'h9: o_pattern = SEG_9;
      4'hA: o_pattern = i_hex_mode ? SEG_A : SEG_BLANK;
      4'hB: o_pattern = i_hex_mode ? SEG_B : SEG_BLANK;
      4'hC: o_pattern = i_hex_mode ? SEG_C : SEG_BLANK;
      4'hD: o_pattern = i_hex_mode ? SEG_D : SEG_BLANK;
      4'hE: o_pattern = i_hex_mode ? SEG_E : SEG_BLANK;
      4'hF: o_pattern = i_hex_mode ? SEG_F : SEG_BLANK;
      default: o_pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment display scanner with frame-synchronous data update.
// Latency: segments/dp/anode registered, one cycle behind the digit index.
// Backpressure: none; a load is always accepted and shown from the next frame.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_value, i_dp         packed nibbles (digit 0 = LSB) and per-digit dp
//   i_load                one-cycle strobe capturing i_value/i_dp
//   i_hex_mode            live: show A-F for nibbles 10-15, else blank
//   i_blank_lz            live: suppress leading zeros (digit 0 never blank)
//   o_segments, o_dp_out  pattern and dp of the selected digit
//   o_anode               one-hot digit select
//   o_frame_done          one-cycle pulse as the scan wraps to digit 0
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [4*NDIGITS-1:0] i_value,
  input  logic [NDIGITS-1:0]   i_dp,
  input  logic                 i_load,
  input  logic                 i_hex_mode,
  input  logic                 i_blank_lz,
  output logic [6:0]           o_segments,
  output logic                 o_dp_out,
  output logic [NDIGITS-1:0]   o_anode,
  output logic                 o_frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NDIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  // XOR masks: all-zero for active-high, all-one for active-low. They are
  // also the all-off level driven during reset.
  localparam logic [6:0]         SEG_OFF   = {7{ACTIVE_LOW}};
  localparam logic [NDIGITS-1:0] ANODE_OFF = {NDIGITS{ACTIVE_LOW}};

  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_idx;
  logic [4*NDIGITS-1:0]   r_pend_val;
  logic [NDIGITS-1:0]     r_pend_dp;
  logic [4*NDIGITS-1:0]   r_act_val;
  logic [NDIGITS-1:0]     r_act_dp;

  logic                   w_tick;
  logic                   w_wrap;
  logic [3:0]             w_nibble;
  logic                   w_dp;
  logic                   w_blank;
  logic                   w_lead_zero;
  logic [NDIGITS-1:0]     w_anode;
  logic [6:0]             w_dec_seg;
  logic [6:0]             w_seg;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Prescaler and digit index.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Double-buffered display data. The active copy only changes on the
  // wrapping tick so one frame never shows a mix of old and new digits;
  // a load landing exactly on that tick bypasses the pending stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (i_load) begin
        r_pend_val <= i_value;
        r_pend_dp  <= i_dp;
      end
      if (w_wrap) begin
        r_act_val <= i_load ? i_value : r_pend_val;
        r_act_dp  <= i_load ? i_dp    : r_pend_dp;
      end
    end
  end

  // Select the current digit's nibble/dp and build the one-hot anode.
  always_comb begin
    w_nibble = '0;
    w_dp     = 1'b0;
    w_anode  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      w_anode[i] = (r_idx == IW'(i));
      if (r_idx == IW'(i)) begin
        w_nibble = r_act_val[4*i +: 4];
        w_dp     = r_act_dp[i];
      end
    end
  end

  // Leading-zero detection: walking down from the top digit, w_lead_zero
  // stays set while every nibble at or above position i is zero. Digit 0
  // is excluded from the walk so it is never blanked.
  always_comb begin
    w_lead_zero = 1'b1;
    w_blank     = 1'b0;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      w_lead_zero = w_lead_zero && (r_act_val[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_blank = w_lead_zero;
      end
    end
  end

  sevenseg_hexdec u_hexdec (
    .i_nibble   (w_nibble),
    .i_hex_mode (i_hex_mode),
    .o_pattern  (w_dec_seg)
  );

  assign w_seg = (i_blank_lz && w_blank) ? SEG_BLANK : w_dec_seg;

  // Output register with polarity applied; dp is not subject to blanking.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_segments   <= SEG_OFF;
      o_dp_out     <= ACTIVE_LOW;
      o_anode      <= ANODE_OFF;
      o_frame_done <= 1'b0;
    end else begin
      o_segments   <= w_seg ^ SEG_OFF;
      o_dp_out     <= w_dp ^ ACTIVE_LOW;
      o_anode      <= w_anode ^ ANODE_OFF;
      o_frame_done <= w_wrap;
    end
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 Parameter NDIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot, legal range 2 or more.
REQ-003 Parameter ACTIVE_LOW, default 0: when 1, segments, dp_out and anode are inverted at the outputs.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 value  input  4*NDIGITS  packed nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
REQ-007 dp  input  NDIGITS  decimal-point request per digit.
REQ-008 load  input  1  one-cycle strobe that captures value and dp.
REQ-009 hex_mode  input  1  1: nibbles 10-15 display A,b,C,d,E,F; 0: nibbles 10-15 blank.
REQ-010 blank_lz  input  1  enables leading-zero suppression.
REQ-011 segments  output  7  abc_defg, bit 6 = a; 1 = lit when ACTIVE_LOW=0.
REQ-012 dp_out  output  1  decimal point of the currently selected digit.
REQ-013 anode  output  NDIGITS  one-hot digit select; 1 = on when ACTIVE_LOW=0.
REQ-014 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 The prescaler shall count 0..REFRESH_DIV-1 and wrap; tick = (prescaler == REFRESH_DIV-1).
REQ-016 On each tick, the digit index shall advance by 1 and wrap from NDIGITS-1 to 0.
REQ-017 frame_done shall be 1 for exactly one cycle: the cycle after the tick on which the index wraps to 0.
REQ-018 On load, value and dp shall be captured into a pending register.
REQ-019 Pending shall be copied to the active register only on the wrapping tick, so a frame never mixes old and new data.
REQ-020 If load and the wrapping tick coincide, the active register shall take the new value and dp directly.
REQ-021 Decode: 0-9 as 7-seg decimal; A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111 when hex_mode=1; else 0000000.
REQ-022 Leading-zero blanking: with blank_lz=1, digit i>0 shall show 0000000 when active nibbles NDIGITS-1 down to i are all zero; digit 0 is never blanked.
REQ-023 dp_out shall follow the active dp bit of the selected digit and is unaffected by blanking.
REQ-024 segments, dp_out and anode shall be registered, lagging the index by exactly one clk cycle.
REQ-025 anode shall be exactly one-hot (pre-polarity) at all times after the first post-reset cycle.
REQ-026 hex_mode and blank_lz shall be sampled live when the output register updates; they are not latched by load.

Reset
REQ-027 On reset, the prescaler, index, pending and active registers, and frame_done shall be cleared to 0.
REQ-028 On reset, segments, dp_out and anode shall go to the all-off level: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
REQ-029 Reset asserted mid-frame shall discard pending data; the scan restarts at digit 0 after release.

Structure
REQ-030 Package sevenseg_pkg shall hold the segment constants for 0-F and the blank pattern.
REQ-031 The nibble-to-segment decode shall be a separate combinational sub-module, sevenseg_hexdec (inputs: nibble, hex_mode; output: 7-bit pattern).
REQ-032 Target size is 120-400 RTL lines.

Verification (NDIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0)
REQ-033 Reset then release, no load -> anode sequence 0001,0010,0100,1000 each held 4 cycles; segments 1111110 throughout; frame_done pulses every 16 cycles.
REQ-034 load value=16'h12A9, hex_mode=1, mid-frame -> old data completes the frame; next frame shows 1111011, 1110111, 1101101, 0110000 for digits 0..3.
REQ-035 load value=16'h0050, blank_lz=1 -> digit3 and digit2 0000000, digit1 1011011, digit0 1111110; repeat with blank_lz=0 -> digits 3 and 2 show 1111110.
REQ-036 hex_mode=0, value=16'h000F -> digit0 0000000; dp=4'b0100 -> dp_out=1 only while anode=0100.
REQ-037 load coincident with the wrapping tick -> new data visible in the frame that starts immediately.
REQ-038 Reset asserted mid-frame with a load pending -> outputs all-off within 0 cycles; after release, active=0 and the pending load is lost; ACTIVE_LOW=1 rerun -> all outputs inverted.
